obc_slice_sequencer: RTL and testbench
======================================

OBC_SLICE_SEQUENCER -- requirements
Module: obc_slice_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning sample width in bits; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a sample block is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample block.
REQ-006 The block SHALL have port in_data, input, 16*W bits: 16 two's-complement samples, sample i at bits [i*W +: W].
REQ-007 The block SHALL have port offset, input, 32 bits: OBC offset constant for this block, captured with in_data.
REQ-008 The block SHALL have port slice_x, output, 16 bits: the current bit slice, with slice_x[i] equal to bit k of sample i; it drives the sixteen x-inputs of the ROM tree.
REQ-009 The block SHALL have port slice_m, output, 1 bit: the sign-slice flag, driven to the ROM tree m input.
REQ-010 The block SHALL have port slice_valid, output, 1 bit: slice_x and slice_m are meaningful this cycle.
REQ-011 The block SHALL have port rom_in, input, 32 bits: the ROM tree's combinational partial sum for the current slice.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-014 The block SHALL have port out_data, output, 32 bits: the DFT bin result.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, SLICE and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; on in_valid && in_ready the block SHALL register in_data and offset, clear the accumulator and the slice counter k to 0, and move to SLICE.
REQ-018 In SLICE, slice_valid SHALL be 1 and slice_x SHALL present bit k of each registered sample, with k taking the values 0, 1, ..., W-1 on consecutive cycles (LSB first).
REQ-019 slice_m SHALL be 1 only in the SLICE cycle where k = W-1 (the sign slice) and 0 in every other cycle.
REQ-020 On each SLICE cycle the block SHALL update acc <= acc + (rom_in << k), computed and truncated modulo 2^32; rom_in is sampled in the same cycle in which its slice is presented.
REQ-021 After the k = W-1 cycle the block SHALL move to DONE and register out_data = acc_final + offset, modulo 2^32.
REQ-022 In DONE, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready is 1; on out_valid && out_ready the block SHALL return to IDLE.
REQ-023 in_ready SHALL be 0 in SLICE and in DONE; a new block cannot be accepted in the same cycle as out handshake, so there is one idle bubble between results.
REQ-024 Latency SHALL be exactly W+1 cycles from the accept edge to out_valid, with no stalls inside SLICE.
REQ-025 Outside SLICE, slice_valid, slice_m and slice_x SHALL all be 0.
REQ-026 in_data and offset changes after acceptance SHALL have no effect on the block in flight.

Reset
REQ-027 While rst_n = 0 the block SHALL force state IDLE, in_ready=1, slice_x=0, slice_m=0, slice_valid=0, out_valid=0, out_data=0, busy=0, and clear acc, k and the sample registers.
REQ-028 Reset asserted mid-SLICE or mid-DONE SHALL discard the block in flight with no out_valid pulse; the first transaction after rst_n rises SHALL behave as after power-up.

Verification
REQ-029 The bench SHALL cover: all samples 0, offset 0, rom_in held at 1 for W=8 -> out_data = 32'd255, out_valid first seen 9 cycles after accept.
REQ-030 The bench SHALL cover: sample 0 = 8'h81, other samples 0 -> slice_x = 16'h0001 at k=0 and k=7, 16'h0000 for k=1..6, and slice_m high only at k=7.
REQ-031 The bench SHALL cover: rom_in = 32'hFFFFFFFF every slice, offset 32'd10 -> out_data = 32'hFFFFFF0B (wrap-around).
REQ-032 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready 0, and in_valid ignored; after out_ready=1 there is one cycle in IDLE before the next accept.
REQ-033 The bench SHALL cover: rst_n pulsed low at k=3 -> all outputs at reset values immediately (asynchronously); the next block returns a correct result with W+1 latency.
REQ-034 The bench SHALL cover: a model ROM tree connected and 16 random sample blocks run -> out_data matches a reference OBC DFT bin computed bit-exactly.

Source files
------------

// File: rtl/obc_slice_sequencer.sv
// ---------------------------------------------------------------------------
// obc_slice_sequencer
//
// Bit-serial sequencer for an offset-binary-coding (OBC) DFT bin. It accepts
// a block of sixteen two's-complement samples and walks through them one bit
// slice at a time, LSB first. Each slice goes out to an external ROM tree,
// which returns a partial sum. The sequencer shift-accumulates those partial
// sums and adds the per-block OBC offset to form the bin result.
//
// Parameters
//   W            sample width in bits (2..16)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream offers a sample block
//   in_ready     sequencer can accept a block (IDLE only)
//   in_data      16 samples, sample i at [i*W +: W]
//   offset       OBC offset constant, captured together with in_data
//   slice_x      current bit slice: slice_x[i] = bit k of sample i
//   slice_m      high on the sign slice (k = W-1)
//   slice_valid  slice_x / slice_m are meaningful this cycle
//   rom_in       ROM tree partial sum for the slice being presented
//   out_valid    result available
//   out_ready    downstream accepts the result
//   out_data     DFT bin result (modulo 2^32)
//   busy         high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module obc_slice_sequencer #(
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [16*W-1:0] in_data,
   input  logic [31:0]     offset,
   output logic [15:0]     slice_x,
   output logic            slice_m,
   output logic            slice_valid,
   input  logic [31:0]     rom_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_data,
   output logic            busy
);

   localparam int KW = (W > 1) ? $clog2(W) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SLICE,
      DONE
   } state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic [KW-1:0] k_next;
   logic [W-1:0]  samp [16];
   logic [31:0]   off_reg;
   logic [31:0]   acc;
   logic [31:0]   acc_sum;

   // Shift-add of the ROM partial sum for the slice on the wires right now.
   // The sign slice needs no special handling here: the ROM tree already
   // negates its partial sum when slice_m is high.
   assign acc_sum = acc + (rom_in << k);
   assign k_next  = k + KW'(1);

   // All interface outputs are registered. The slice for step k+1 is loaded
   // on the same edge that consumes the ROM result for step k, so the slice
   // pipeline runs without stalls and rom_in always belongs to the slice
   // currently presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         k           <= '0;
         off_reg     <= '0;
         acc         <= '0;
         in_ready    <= 1'b1;
         slice_x     <= '0;
         slice_m     <= 1'b0;
         slice_valid <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         busy        <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            samp[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < 16; i++) begin
                     samp[i]    <= in_data[i*W +: W];
                     slice_x[i] <= in_data[i*W];
                  end
                  off_reg     <= offset;
                  acc         <= '0;
                  k           <= '0;
                  slice_m     <= 1'b0;
                  slice_valid <= 1'b1;
                  in_ready    <= 1'b0;
                  busy        <= 1'b1;
                  state       <= SLICE;
               end
            end

            SLICE: begin
               acc <= acc_sum;
               if (k == K_LAST) begin
                  out_data    <= acc_sum + off_reg;
                  out_valid   <= 1'b1;
                  slice_x     <= '0;
                  slice_m     <= 1'b0;
                  slice_valid <= 1'b0;
                  state       <= DONE;
               end else begin
                  for (int i = 0; i < 16; i++) begin
                     slice_x[i] <= samp[i][k_next];
                  end
                  slice_m <= (k_next == K_LAST);
                  k       <= k_next;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obc_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_obc_slice_sequencer
//
// Directed bench for obc_slice_sequencer (W = 8). Inputs are driven and
// outputs sampled on the falling clock edge. The cycle in which a block is
// offered and accepted is called cycle 0. The DUT presents slices k = 0..7
// in cycles 1..8, and the result appears in cycle 9.
// A model ROM tree with random coefficients can be switched onto rom_in.
// That path is used to cross-check whole blocks against a signed dot
// product computed in the bench.
// ---------------------------------------------------------------------------
module tb_obc_slice_sequencer;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [16*W-1:0] in_data;
   logic [31:0]     offset;
   logic [15:0]     slice_x;
   logic            slice_m;
   logic            slice_valid;
   logic [31:0]     rom_in;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_data;
   logic            busy;

   logic [31:0]     romDirected;
   logic            useModel;
   int              coef [16];
   int              romSum;
   int              vectorCount = 0;
   int              missCount = 0;

   obc_slice_sequencer #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .offset      (offset),
      .slice_x     (slice_x),
      .slice_m     (slice_m),
      .slice_valid (slice_valid),
      .rom_in      (rom_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Model ROM tree: sum of the coefficients whose x-input is set, negated
   // on the sign slice. Otherwise a constant directed value drives rom_in.
   always_comb begin
      romSum = 0;
      for (int i = 0; i < 16; i++) begin
         if (slice_x[i]) romSum = romSum + coef[i];
      end
      if (slice_m) romSum = -romSum;
      rom_in = useModel ? 32'(romSum) : romDirected;
   end

   // Reference bin: signed dot product of samples and coefficients plus offset.
   function automatic logic [31:0] refBin(input logic [16*W-1:0] d, input logic [31:0] off);
      int               sum;
      logic signed [W-1:0] s;
      sum = int'(off);
      for (int i = 0; i < 16; i++) begin
         s   = d[i*W +: W];
         sum = sum + coef[i] * int'(s);
      end
      return 32'(sum);
   endfunction

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      assert (observed === expected)
      else begin
         missCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Every output must sit at its reset value.
   task automatic checkResetValues(input string prefix);
      checkOutput({prefix, "_in_ready"},    32'(in_ready),    32'd1);
      checkOutput({prefix, "_busy"},        32'(busy),        32'd0);
      checkOutput({prefix, "_out_valid"},   32'(out_valid),   32'd0);
      checkOutput({prefix, "_out_data"},    out_data,         32'd0);
      checkOutput({prefix, "_slice_valid"}, 32'(slice_valid), 32'd0);
      checkOutput({prefix, "_slice_m"},     32'(slice_m),     32'd0);
      checkOutput({prefix, "_slice_x"},     32'(slice_x),     32'd0);
   endtask

   // Offer a block in the current cycle (cycle 0).
   task automatic applyStimulus(input logic [16*W-1:0] data, input logic [31:0] off, input logic [31:0] rom);
      in_valid    = 1'b1;
      in_data     = data;
      offset      = off;
      romDirected = rom;
      checkOutput("offer_in_ready", 32'(in_ready), 32'd1);
   endtask

   // Step from cycle 0 to cycle 9. Scramble the input bus after acceptance,
   // then check the latency and the result.
   task automatic runToResult(input string tag, input logic [31:0] expected);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~in_data;
      offset   = offset ^ 32'hDEAD_BEEF;
      checkOutput({tag, "_busy"},     32'(busy),        32'd1);
      checkOutput({tag, "_in_ready"}, 32'(in_ready),    32'd0);
      checkOutput({tag, "_svalid"},   32'(slice_valid), 32'd1);
      repeat (7) @(negedge clk);
      checkOutput({tag, "_early_ovalid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput({tag, "_out_valid"}, 32'(out_valid),   32'd1);
      checkOutput({tag, "_out_data"},  out_data,         expected);
      checkOutput({tag, "_svalid_d"},  32'(slice_valid), 32'd0);
   endtask

   // Hand the result off and confirm the return to IDLE.
   task automatic releaseResult(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, "_rel_ovalid"},  32'(out_valid), 32'd0);
      checkOutput({tag, "_rel_inready"}, 32'(in_ready),  32'd1);
      checkOutput({tag, "_rel_busy"},    32'(busy),      32'd0);
   endtask

   initial begin
      logic [16*W-1:0] data;
      logic [31:0]     off;

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_data     = '0;
      offset      = '0;
      romDirected = '0;
      useModel    = 1'b0;
      for (int i = 0; i < 16; i++) coef[i] = int'($urandom);

      // Reset state
      repeat (2) @(negedge clk);
      checkResetValues("rst");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

      // Zero samples, rom_in = 1: sum of 2^k for k = 0..7
      applyStimulus('0, 32'd0, 32'd1);
      runToResult("ones", 32'd255);
      releaseResult("ones");

      // Slice pattern for sample 0 = 0x81
      data = '0;
      data[7:0] = 8'h81;
      applyStimulus(data, 32'd0, 32'd0);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checkOutput($sformatf("pat_x_k%0d", k), 32'(slice_x),
                     (k == 0 || k == W - 1) ? 32'h0001 : 32'h0000);
         checkOutput($sformatf("pat_m_k%0d", k), 32'(slice_m),
                     (k == W - 1) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      checkOutput("pat_out_valid", 32'(out_valid), 32'd1);
      checkOutput("pat_out_data",  out_data,       32'd0);
      checkOutput("pat_x_done",    32'(slice_x),   32'd0);
      checkOutput("pat_m_done",    32'(slice_m),   32'd0);
      releaseResult("pat");

      // Wrap-around: -255 + 10
      applyStimulus({16{8'h5A}}, 32'd10, 32'hFFFF_FFFF);
      runToResult("wrap", 32'hFFFF_FF0B);
      releaseResult("wrap");

      // Back-pressure in DONE with a competing offer, then one idle bubble
      applyStimulus('0, 32'd5, 32'd1);
      runToResult("hold", 32'd260);
      in_valid = 1'b1;
      in_data  = '0;
      offset   = 32'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("hold_ovalid_c%0d", c),  32'(out_valid), 32'd1);
         checkOutput($sformatf("hold_data_c%0d", c),    out_data,       32'd260);
         checkOutput($sformatf("hold_inready_c%0d", c), 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("bubble_ovalid",  32'(out_valid), 32'd0);
      checkOutput("bubble_inready", 32'(in_ready),  32'd1);
      checkOutput("bubble_busy",    32'(busy),      32'd0);
      runToResult("next", 32'd255);
      releaseResult("next");

      // Asynchronous reset at k = 3
      applyStimulus({16{8'h33}}, 32'd7, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("k3_svalid", 32'(slice_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 checkResetValues("async");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput($sformatf("discard_ovalid_c%0d", c), 32'(out_valid), 32'd0);
      end
      applyStimulus('0, 32'd3, 32'd1);
      runToResult("post_rst", 32'd258);
      releaseResult("post_rst");

      // Random blocks through the model ROM tree
      useModel = 1'b1;
      for (int b = 0; b < 16; b++) begin
         data = '0;
         for (int i = 0; i < 16; i++) data[i*W +: W] = W'($urandom);
         off = $urandom;
         applyStimulus(data, off, 32'd0);
         runToResult($sformatf("rand%0d", b), refBin(data, off));
         releaseResult($sformatf("rand%0d", b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
